ch_map_arbiter: RTL and testbench

Arbitrates the single-port character-map RAM between the VGA fetch path and the CPU/APB register side. The VGA path supplies the character-map address computed from the beam position and has priority. CPU reads and writes are accepted on a valid/ready handshake into slots the VGA path leaves free. A starvation counter guarantees CPU progress; any VGA fetch the counter displaces is flagged.

---
 rtl/vgachargen_pkg.sv | 19 +
 rtl/ch_map_arbiter.sv | 125 ++++++++++++
 tb/tb_ch_map_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vgachargen_pkg.sv
// Shared types and widths for the VGA character generator, including the
// character-map RAM arbiter.
package vgachargen_pkg;

  // 80 x 30 = 2400 character cells fit in a 12-bit address
  localparam int unsigned CH_MAP_ADDR_WIDTH = 12;
  localparam int unsigned CH_MAP_DATA_WIDTH = 8;

  // Width of the CPU starvation counter; holds limits up to 15
  localparam int unsigned STARVE_CNT_WIDTH = 4;

  // CPU-side transaction state of the character-map arbiter
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } ch_map_arb_state_e;

endpackage

// File: rtl/ch_map_arbiter.sv
// Character-map RAM arbiter: the VGA fetch path has priority, the CPU fills
// free slots on a valid/ready handshake, and a starvation counter forces a
// CPU slot after STARVE_LIMIT blocked cycles (flagging the displaced fetch).
module ch_map_arbiter
  import vgachargen_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         vga_req_i,
  input  logic [CH_MAP_ADDR_WIDTH-1:0] vga_addr_i,
  output logic                         vga_rvalid_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] vga_rdata_o,
  output logic                         vga_miss_o,
  input  logic                         cpu_valid_i,
  input  logic                         cpu_we_i,
  input  logic [CH_MAP_ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                         cpu_ready_o,
  output logic                         cpu_rvalid_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                         cpu_rready_i,
  output logic                         mem_en_o,
  output logic                         mem_we_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0] mem_rdata_i
);

  localparam logic [STARVE_CNT_WIDTH-1:0] StarveLimitC = STARVE_CNT_WIDTH'(STARVE_LIMIT);

  ch_map_arb_state_e state_q, state_d;
  logic [STARVE_CNT_WIDTH-1:0]  starve_q, starve_d;
  logic [CH_MAP_DATA_WIDTH-1:0] cpuRdata_q, cpuRdata_d;
  logic                         vgaRvalid_q, vgaRvalid_d;
  logic                         vgaMiss_q, vgaMiss_d;

  logic cpuEligible;
  logic grantVga;
  logic grantCpu;

  // Decide who owns the RAM port this cycle; no grants while reset is held
  always_comb begin
    cpuEligible = cpu_valid_i &&
                  ((state_q == IDLE) || ((state_q == RESP) && cpu_rready_i));
    grantVga    = !rst_i && vga_req_i && (!cpuEligible || (starve_q < StarveLimitC));
    grantCpu    = !rst_i && !grantVga && cpuEligible;
  end

  // Drive the RAM port from whichever side won the slot
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (grantCpu) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
    end else if (grantVga) begin
      mem_en_o    = 1'b1;
      mem_addr_o  = vga_addr_i;
    end
  end

  // Next-state logic for the CPU transaction FSM and its side registers
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cpuRdata_d  = cpuRdata_q;
    vgaRvalid_d = grantVga;
    vgaMiss_d   = vga_req_i && grantCpu;

    if (!cpu_valid_i || grantCpu) begin
      starve_d = '0;
    end else if (cpuEligible && grantVga && (starve_q < StarveLimitC)) begin
      starve_d = starve_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (grantCpu && !cpu_we_i) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        cpuRdata_d = mem_rdata_i;
        state_d    = RESP;
      end
      RESP: begin
        if (cpu_rready_i) begin
          state_d = (grantCpu && !cpu_we_i) ? RD_WAIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      cpuRdata_q  <= '0;
      vgaRvalid_q <= 1'b0;
      vgaMiss_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cpuRdata_q  <= cpuRdata_d;
      vgaRvalid_q <= vgaRvalid_d;
      vgaMiss_q   <= vgaMiss_d;
    end
  end

  assign cpu_ready_o  = grantCpu;
  assign cpu_rvalid_o = (state_q == RESP);
  assign cpu_rdata_o  = cpuRdata_q;
  assign vga_rvalid_o = vgaRvalid_q;
  assign vga_miss_o   = vgaMiss_q;
  assign vga_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_ch_map_arbiter.sv
// Directed bench for ch_map_arbiter with a behavioural single-port RAM.
module tb_ch_map_arbiter;
  import vgachargen_pkg::*;

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b1;
  logic                         vga_req_i = 1'b0;
  logic [CH_MAP_ADDR_WIDTH-1:0] vga_addr_i = '0;
  logic                         vga_rvalid_o;
  logic [CH_MAP_DATA_WIDTH-1:0] vga_rdata_o;
  logic                         vga_miss_o;
  logic                         cpu_valid_i = 1'b0;
  logic                         cpu_we_i = 1'b0;
  logic [CH_MAP_ADDR_WIDTH-1:0] cpu_addr_i = '0;
  logic [CH_MAP_DATA_WIDTH-1:0] cpu_wdata_i = '0;
  logic                         cpu_ready_o;
  logic                         cpu_rvalid_o;
  logic [CH_MAP_DATA_WIDTH-1:0] cpu_rdata_o;
  logic                         cpu_rready_i = 1'b0;
  logic                         mem_en_o;
  logic                         mem_we_o;
  logic [CH_MAP_ADDR_WIDTH-1:0] mem_addr_o;
  logic [CH_MAP_DATA_WIDTH-1:0] mem_wdata_o;
  logic [CH_MAP_DATA_WIDTH-1:0] memRdata = '0;

  logic [CH_MAP_DATA_WIDTH-1:0] ramModel [0:4095];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        vreq;
    logic [11:0] vaddr;
    logic        cv;
    logic        we;
    logic [11:0] caddr;
    logic [7:0]  wd;
    logic        rr;
    logic        rdy;
    logic        en;
    logic        mwe;
    logic [11:0] maddr;
    logic [7:0]  mwd;
    logic        vrv;
    logic [7:0]  vrd;
    logic        miss;
    logic        crv;
    logic [7:0]  crd;
  } vector_t;

  vector_t vecs [12];

  ch_map_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .vga_req_i    (vga_req_i),
    .vga_addr_i   (vga_addr_i),
    .vga_rvalid_o (vga_rvalid_o),
    .vga_rdata_o  (vga_rdata_o),
    .vga_miss_o   (vga_miss_o),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_ready_o  (cpu_ready_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_rready_i (cpu_rready_i),
    .mem_en_o     (mem_en_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (memRdata)
  );

  always #5 clk_i = ~clk_i;

  // Single-port synchronous RAM: read data one cycle after enable
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) ramModel[mem_addr_o] <= mem_wdata_o;
      else          memRdata <= ramModel[mem_addr_o];
    end
  end

  // Hard stop in case anything stalls the main sequence
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, let logic settle
  task automatic applyStimulus(input logic vreq, input logic [11:0] vaddr,
                               input logic cv, input logic we, input logic [11:0] caddr,
                               input logic [7:0] wd, input logic rr);
    @(posedge clk_i);
    #1;
    vga_req_i    = vreq;
    vga_addr_i   = vaddr;
    cpu_valid_i  = cv;
    cpu_we_i     = we;
    cpu_addr_i   = caddr;
    cpu_wdata_i  = wd;
    cpu_rready_i = rr;
    #1;
  endtask

  task automatic checkVector(input vector_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    checkOutput({p, ".cpu_ready"},  32'(cpu_ready_o),  32'(v.rdy));
    checkOutput({p, ".mem_en"},     32'(mem_en_o),     32'(v.en));
    checkOutput({p, ".mem_we"},     32'(mem_we_o),     32'(v.mwe));
    checkOutput({p, ".mem_addr"},   32'(mem_addr_o),   32'(v.maddr));
    checkOutput({p, ".mem_wdata"},  32'(mem_wdata_o),  32'(v.mwd));
    checkOutput({p, ".vga_rvalid"}, 32'(vga_rvalid_o), 32'(v.vrv));
    checkOutput({p, ".vga_miss"},   32'(vga_miss_o),   32'(v.miss));
    checkOutput({p, ".cpu_rvalid"}, 32'(cpu_rvalid_o), 32'(v.crv));
    checkOutput({p, ".cpu_rdata"},  32'(cpu_rdata_o),  32'(v.crd));
    if (v.vrv) checkOutput({p, ".vga_rdata"}, 32'(vga_rdata_o), 32'(v.vrd));
  endtask

  initial begin
    int written;
    int badCells;
    logic prevVreq;

    for (int i = 0; i < 4096; i++) ramModel[i] = 8'h00;

    //          vreq vaddr   cv we caddr   wd     rr | rdy en mwe maddr  mwd   vrv vrd   miss crv crd
    vecs[0]  = '{0, 12'd0, 1, 1, 12'd0, 8'hA5, 0,  1, 1, 1, 12'd0, 8'hA5, 0, 8'h00, 0, 0, 8'h00};
    vecs[1]  = '{0, 12'd0, 1, 0, 12'd0, 8'h00, 0,  1, 1, 0, 12'd0, 8'h00, 0, 8'h00, 0, 0, 8'h00};
    vecs[2]  = '{0, 12'd0, 0, 0, 12'd0, 8'h00, 0,  0, 0, 0, 12'd0, 8'h00, 0, 8'h00, 0, 0, 8'h00};
    vecs[3]  = '{0, 12'd0, 0, 0, 12'd0, 8'h00, 0,  0, 0, 0, 12'd0, 8'h00, 0, 8'h00, 0, 1, 8'hA5};
    vecs[4]  = '{0, 12'd0, 0, 0, 12'd0, 8'h00, 1,  0, 0, 0, 12'd0, 8'h00, 0, 8'h00, 0, 1, 8'hA5};
    vecs[5]  = '{0, 12'd0, 0, 0, 12'd0, 8'h00, 0,  0, 0, 0, 12'd0, 8'h00, 0, 8'h00, 0, 0, 8'hA5};
    vecs[6]  = '{1, 12'd0, 0, 0, 12'd0, 8'h00, 0,  0, 1, 0, 12'd0, 8'h00, 0, 8'h00, 0, 0, 8'hA5};
    vecs[7]  = '{0, 12'd0, 0, 0, 12'd0, 8'h00, 0,  0, 0, 0, 12'd0, 8'h00, 1, 8'hA5, 0, 0, 8'hA5};
    vecs[8]  = '{1, 12'd5, 1, 1, 12'd5, 8'h3C, 0,  0, 1, 0, 12'd5, 8'h00, 0, 8'h00, 0, 0, 8'hA5};
    vecs[9]  = '{0, 12'd0, 1, 1, 12'd5, 8'h3C, 0,  1, 1, 1, 12'd5, 8'h3C, 1, 8'h00, 0, 0, 8'hA5};
    vecs[10] = '{1, 12'd5, 0, 0, 12'd0, 8'h00, 0,  0, 1, 0, 12'd5, 8'h00, 0, 8'h00, 0, 0, 8'hA5};
    vecs[11] = '{0, 12'd0, 0, 0, 12'd0, 8'h00, 0,  0, 0, 0, 12'd0, 8'h00, 1, 8'h3C, 0, 0, 8'hA5};

    // Reset state
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst.cpu_ready",  32'(cpu_ready_o),  0);
    checkOutput("rst.cpu_rvalid", 32'(cpu_rvalid_o), 0);
    checkOutput("rst.cpu_rdata",  32'(cpu_rdata_o),  0);
    checkOutput("rst.vga_rvalid", 32'(vga_rvalid_o), 0);
    checkOutput("rst.vga_miss",   32'(vga_miss_o),   0);
    checkOutput("rst.mem_en",     32'(mem_en_o),     0);
    rst_i = 1'b0;

    // Table: isolated write/read, VGA fetches, VGA/CPU contention
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].vreq, vecs[i].vaddr, vecs[i].cv, vecs[i].we,
                    vecs[i].caddr, vecs[i].wd, vecs[i].rr);
      checkVector(vecs[i], i);
    end

    // Starvation: VGA held high, CPU read of addr 5 wins on the 5th cycle
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 12'd7, 1, 0, 12'd5, 8'h00, 0);
      checkOutput($sformatf("starve.ready%0d", k), 32'(cpu_ready_o), 32'(k == 5));
      checkOutput($sformatf("starve.miss%0d", k), 32'(vga_miss_o), 0);
      if (k >= 2) checkOutput($sformatf("starve.vrv%0d", k), 32'(vga_rvalid_o), 1);
    end
    checkOutput("starve.maddr", 32'(mem_addr_o), 5);
    applyStimulus(1, 12'd7, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("starve.miss_pulse", 32'(vga_miss_o), 1);
    checkOutput("starve.vrv_miss",   32'(vga_rvalid_o), 0);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("starve.miss_once", 32'(vga_miss_o), 0);
    checkOutput("starve.vrv_after", 32'(vga_rvalid_o), 1);
    checkOutput("starve.crv",       32'(cpu_rvalid_o), 1);
    checkOutput("starve.crd",       32'(cpu_rdata_o), 32'h3C);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 1);

    // Back-pressure: response held while rready is low for 10 cycles
    applyStimulus(0, 12'd0, 1, 0, 12'd0, 8'h00, 0);
    checkOutput("bp.ready_first", 32'(cpu_ready_o), 1);
    applyStimulus(0, 12'd0, 1, 0, 12'd5, 8'h00, 0);
    checkOutput("bp.ready_rdwait", 32'(cpu_ready_o), 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 12'd0, 1, 0, 12'd5, 8'h00, 0);
      checkOutput($sformatf("bp.crv%0d", i),   32'(cpu_rvalid_o), 1);
      checkOutput($sformatf("bp.crd%0d", i),   32'(cpu_rdata_o), 32'hA5);
      checkOutput($sformatf("bp.ready%0d", i), 32'(cpu_ready_o), 0);
    end
    applyStimulus(0, 12'd0, 1, 0, 12'd5, 8'h00, 1);
    checkOutput("bp.ready_on_rready", 32'(cpu_ready_o), 1);
    checkOutput("bp.maddr",           32'(mem_addr_o), 5);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("bp.crv_rdwait", 32'(cpu_rvalid_o), 0);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("bp.crv2", 32'(cpu_rvalid_o), 1);
    checkOutput("bp.crd2", 32'(cpu_rdata_o), 32'h3C);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 1);

    // Address boundary: CPU at 2399 then VGA at 0 on back-to-back cycles
    applyStimulus(0, 12'd0, 1, 1, 12'd2399, 8'h77, 0);
    checkOutput("bnd.wr_ready", 32'(cpu_ready_o), 1);
    applyStimulus(0, 12'd0, 1, 0, 12'd2399, 8'h00, 0);
    checkOutput("bnd.rd_ready", 32'(cpu_ready_o), 1);
    checkOutput("bnd.rd_addr",  32'(mem_addr_o), 2399);
    applyStimulus(1, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("bnd.vga_en",   32'(mem_en_o), 1);
    checkOutput("bnd.vga_addr", 32'(mem_addr_o), 0);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("bnd.vrv", 32'(vga_rvalid_o), 1);
    checkOutput("bnd.vrd", 32'(vga_rdata_o), 32'hA5);
    checkOutput("bnd.crv", 32'(cpu_rvalid_o), 1);
    checkOutput("bnd.crd", 32'(cpu_rdata_o), 32'h77);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 1);

    // Streaming: 20 CPU writes interleaved with a VGA fetch of 79 every 8th cycle
    applyStimulus(0, 12'd0, 1, 1, 12'd79, 8'h4F, 0);
    checkOutput("strm.pre_ready", 32'(cpu_ready_o), 1);
    written  = 0;
    prevVreq = 1'b0;
    for (int c = 0; c < 60 && written < 20; c++) begin
      applyStimulus((c % 8) == 0, 12'd79, 1, 1, 12'(100 + written), 8'(written + 1), 0);
      checkOutput($sformatf("strm.vrv%0d", c),  32'(vga_rvalid_o), 32'(prevVreq));
      checkOutput($sformatf("strm.miss%0d", c), 32'(vga_miss_o), 0);
      if (prevVreq) checkOutput($sformatf("strm.vrd%0d", c), 32'(vga_rdata_o), 32'h4F);
      if (cpu_ready_o) written++;
      prevVreq = ((c % 8) == 0);
    end
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("strm.written", 32'(written), 20);
    badCells = 0;
    for (int n = 0; n < 20; n++) begin
      if (ramModel[100 + n] !== 8'(n + 1)) badCells++;
    end
    checkOutput("strm.ram_contents", 32'(badCells), 0);

    // Reset while a read sits in RD_WAIT
    applyStimulus(0, 12'd0, 1, 1, 12'd9, 8'h5A, 0);
    checkOutput("rrst.wr_ready", 32'(cpu_ready_o), 1);
    applyStimulus(0, 12'd0, 1, 0, 12'd9, 8'h00, 0);
    checkOutput("rrst.rd_ready", 32'(cpu_ready_o), 1);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    rst_i = 1'b1;
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("rrst.cpu_rvalid", 32'(cpu_rvalid_o), 0);
    checkOutput("rrst.cpu_rdata",  32'(cpu_rdata_o), 0);
    checkOutput("rrst.cpu_ready",  32'(cpu_ready_o), 0);
    checkOutput("rrst.vga_rvalid", 32'(vga_rvalid_o), 0);
    checkOutput("rrst.vga_miss",   32'(vga_miss_o), 0);
    checkOutput("rrst.mem_en",     32'(mem_en_o), 0);
    checkOutput("rrst.mem_we",     32'(mem_we_o), 0);
    checkOutput("rrst.mem_addr",   32'(mem_addr_o), 0);
    checkOutput("rrst.mem_wdata",  32'(mem_wdata_o), 0);
    rst_i = 1'b0;
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("rrst.still_idle", 32'(cpu_rvalid_o), 0);
    applyStimulus(0, 12'd0, 1, 0, 12'd9, 8'h00, 0);
    checkOutput("rrst.reread_ready", 32'(cpu_ready_o), 1);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 0);
    checkOutput("rrst.reread_crv", 32'(cpu_rvalid_o), 1);
    checkOutput("rrst.reread_crd", 32'(cpu_rdata_o), 32'h5A);
    applyStimulus(0, 12'd0, 0, 0, 12'd0, 8'h00, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
